// File: rtl/scaler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scaler_pkg
// Brief    : Shared types and constants for the scaler write-back scheduler.
// Revision : 1.0
// ============================================================================
package scaler_pkg;

    localparam int ADDR_W  = 28;
    localparam int BLEN_W  = 10;
    localparam int c_DIM_W = 13;

    localparam logic [ADDR_W-1:0] c_DEFAULT_BASE = 28'h0003_8540;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_WAIT_FIN = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

    localparam logic [1:0] c_ST_IDLE     = ST_IDLE;
    localparam logic [1:0] c_ST_RUN      = ST_RUN;
    localparam logic [1:0] c_ST_WAIT_FIN = ST_WAIT_FIN;
    localparam logic [1:0] c_ST_DONE     = ST_DONE;

endpackage
`default_nettype wire

// File: rtl/sync_pix_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_pix_fifo
// Brief    : Single-clock first-word-fall-through pixel FIFO with occupancy.
// Revision : 1.0
// ============================================================================
module sync_pix_fifo #(
    parameter int PIX_WIDTH  = 16,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         push,
    input  logic [PIX_WIDTH-1:0]         push_data,
    input  logic                         pop,
    output logic [PIX_WIDTH-1:0]         head,
    output logic [$clog2(FIFO_DEPTH):0]  count,
    output logic                         full,
    output logic                         empty
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);

    logic [PIX_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W:0]     r_wr_ptr;
    logic [c_PTR_W:0]     r_rd_ptr;

    // Callers only push when there is room (or a pop frees a slot this cycle)
    // and only pop when non-empty, so no qualification is repeated here.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr[c_PTR_W-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + (c_PTR_W+1)'(1);
            if (pop)  r_rd_ptr <= r_rd_ptr + (c_PTR_W+1)'(1);
        end
    end

    assign head  = r_mem[r_rd_ptr[c_PTR_W-1:0]];
    assign count = r_wr_ptr - r_rd_ptr;
    assign full  = (count == (c_PTR_W+1)'(FIFO_DEPTH));
    assign empty = (r_wr_ptr == r_rd_ptr);

endmodule
`default_nettype wire

// File: rtl/scaler_wr_sched.sv
`default_nettype none
// ============================================================================
// Module   : scaler_wr_sched
// Brief    : Frame-shadowed scaler config plus row-aligned DDR3 write bursts.
// Revision : 1.0
// ============================================================================
module scaler_wr_sched
    import scaler_pkg::*;
#(
    parameter int FIX_LEN     = 15,
    parameter int PIX_WIDTH   = 16,
    parameter int BURST_LEN   = 32,
    parameter int FIFO_DEPTH  = 64,
    parameter int LINE_STRIDE = 640
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [FIX_LEN-1:0]   cfg_x_scale,
    input  logic [FIX_LEN-1:0]   cfg_y_scale,
    input  logic [12:0]          cfg_h_num,
    input  logic [12:0]          cfg_v_num,
    input  logic [ADDR_W-1:0]    cfg_base_addr,
    input  logic                 frame_start,
    output logic [FIX_LEN-1:0]   x_scale,
    output logic [FIX_LEN-1:0]   y_scale,
    output logic [12:0]          TARGET_H_NUM,
    output logic [12:0]          TARGET_V_NUM,
    input  logic [PIX_WIDTH-1:0] pix_data,
    input  logic                 data_vaild,
    output logic                 wr_burst_req,
    output logic [ADDR_W-1:0]    wr_burst_addr,
    output logic [BLEN_W-1:0]    wr_burst_len,
    input  logic                 wr_burst_data_req,
    output logic [PIX_WIDTH-1:0] wr_burst_data,
    input  logic                 wr_burst_finish,
    output logic                 frame_busy,
    output logic                 frame_done,
    output logic                 ovf_err
);

    localparam int                c_CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] c_STRIDE = ADDR_W'(LINE_STRIDE);

    logic [1:0]             r_state;
    logic [FIX_LEN-1:0]     r_x_scale, r_y_scale;
    logic [c_DIM_W-1:0]     r_h, r_v;
    logic [ADDR_W-1:0]      r_base;
    logic [c_DIM_W-1:0]     r_in_col, r_in_row, r_out_col, r_out_row;
    logic                   r_req;
    logic [ADDR_W-1:0]      r_addr;
    logic [BLEN_W-1:0]      r_len, r_pop_cnt;
    logic [PIX_WIDTH-1:0]   r_last_pix;
    logic                   r_ovf;

    logic [c_CNT_W-1:0]     w_count;
    logic                   w_full, w_empty;
    logic [PIX_WIDTH-1:0]   w_head;
    logic                   w_load, w_in_take, w_pop, w_push_ok, w_drop;
    logic [c_DIM_W-1:0]     w_remain, w_col_next;
    logic [BLEN_W-1:0]      w_need;
    logic [ADDR_W-1:0]      w_addr;

    assign w_load    = (r_state == c_ST_IDLE) && frame_start;
    assign w_in_take = (r_state != c_ST_IDLE) && data_vaild && (r_in_row < r_v);
    // The pop counter stops over-long data requests from draining the next burst.
    assign w_pop     = (r_state == c_ST_WAIT_FIN) && wr_burst_data_req && !w_empty
                       && (r_pop_cnt < r_len);
    assign w_push_ok = w_in_take && (!w_full || w_pop);
    assign w_drop    = w_in_take && w_full && !w_pop;

    assign w_remain   = r_h - r_out_col;
    assign w_need     = (w_remain > c_DIM_W'(BURST_LEN)) ? BLEN_W'(BURST_LEN)
                                                         : w_remain[BLEN_W-1:0];
    assign w_addr     = r_base + ADDR_W'(r_out_row) * c_STRIDE + ADDR_W'(r_out_col);
    assign w_col_next = r_out_col + c_DIM_W'(r_len);

    sync_pix_fifo #(
        .PIX_WIDTH  (PIX_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (w_push_ok),
        .push_data (pix_data),
        .pop       (w_pop),
        .head      (w_head),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_in_col <= '0;
            r_in_row <= '0;
        end else if (w_load) begin
            r_in_col <= '0;
            r_in_row <= '0;
        end else if (w_in_take) begin
            if (r_in_col == r_h - c_DIM_W'(1)) begin
                r_in_col <= '0;
                r_in_row <= r_in_row + c_DIM_W'(1);
            end else begin
                r_in_col <= r_in_col + c_DIM_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= c_ST_IDLE;
            r_x_scale  <= '0;
            r_y_scale  <= '0;
            r_h        <= '0;
            r_v        <= '0;
            r_base     <= c_DEFAULT_BASE;
            r_out_col  <= '0;
            r_out_row  <= '0;
            r_req      <= 1'b0;
            r_addr     <= '0;
            r_len      <= '0;
            r_pop_cnt  <= '0;
            r_last_pix <= '0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (frame_start) begin
                        r_x_scale <= cfg_x_scale;
                        r_y_scale <= cfg_y_scale;
                        r_h       <= cfg_h_num;
                        r_v       <= cfg_v_num;
                        r_base    <= cfg_base_addr;
                        r_out_col <= '0;
                        r_out_row <= '0;
                        r_state   <= c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    if ((int'(w_count) >= int'(w_need)) && (r_out_row < r_v)) begin
                        r_req     <= 1'b1;
                        r_addr    <= w_addr;
                        r_len     <= w_need;
                        r_pop_cnt <= '0;
                        r_state   <= c_ST_WAIT_FIN;
                    end
                end
                c_ST_WAIT_FIN: begin
                    if (wr_burst_finish) begin
                        r_req <= 1'b0;
                        if (w_col_next == r_h) begin
                            r_out_col <= '0;
                            r_out_row <= r_out_row + c_DIM_W'(1);
                            r_state   <= (r_out_row + c_DIM_W'(1) == r_v) ? c_ST_DONE : c_ST_RUN;
                        end else begin
                            r_out_col <= w_col_next;
                            r_state   <= c_ST_RUN;
                        end
                    end
                end
                c_ST_DONE: r_state <= c_ST_IDLE;
                default:   r_state <= c_ST_IDLE;
            endcase

            if (w_pop) begin
                r_pop_cnt  <= r_pop_cnt + BLEN_W'(1);
                r_last_pix <= w_head;
            end
            if (w_drop) r_ovf <= 1'b1;
        end
    end

    assign x_scale       = r_x_scale;
    assign y_scale       = r_y_scale;
    assign TARGET_H_NUM  = r_h;
    assign TARGET_V_NUM  = r_v;
    assign wr_burst_req  = r_req;
    assign wr_burst_addr = r_addr;
    assign wr_burst_len  = r_len;
    assign wr_burst_data = w_pop ? w_head : r_last_pix;
    assign frame_busy    = (r_state != c_ST_IDLE);
    assign frame_done    = (r_state == c_ST_DONE);
    assign ovf_err       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_scaler_wr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_scaler_wr_sched
// Brief    : Scoreboard bench for scaler_wr_sched with a simple DDR responder.
// Revision : 1.0
// ============================================================================
module tb_scaler_wr_sched;

    localparam int FIX_LEN     = 15;
    localparam int PIX_WIDTH   = 16;
    localparam int BURST_LEN   = 32;
    localparam int FIFO_DEPTH  = 64;
    localparam int LINE_STRIDE = 640;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic [FIX_LEN-1:0]   cfg_x_scale, cfg_y_scale;
    logic [12:0]          cfg_h_num, cfg_v_num;
    logic [27:0]          cfg_base_addr;
    logic                 frame_start;
    logic [FIX_LEN-1:0]   x_scale, y_scale;
    logic [12:0]          TARGET_H_NUM, TARGET_V_NUM;
    logic [PIX_WIDTH-1:0] pix_data;
    logic                 data_vaild;
    logic                 wr_burst_req;
    logic [27:0]          wr_burst_addr;
    logic [9:0]           wr_burst_len;
    logic                 wr_burst_data_req;
    logic [PIX_WIDTH-1:0] wr_burst_data;
    logic                 wr_burst_finish;
    logic                 frame_busy, frame_done, ovf_err;

    always #5 clk = ~clk;

    scaler_wr_sched #(
        .FIX_LEN(FIX_LEN), .PIX_WIDTH(PIX_WIDTH), .BURST_LEN(BURST_LEN),
        .FIFO_DEPTH(FIFO_DEPTH), .LINE_STRIDE(LINE_STRIDE)
    ) dut (
        .clk(clk), .rstn(rstn),
        .cfg_x_scale(cfg_x_scale), .cfg_y_scale(cfg_y_scale),
        .cfg_h_num(cfg_h_num), .cfg_v_num(cfg_v_num), .cfg_base_addr(cfg_base_addr),
        .frame_start(frame_start),
        .x_scale(x_scale), .y_scale(y_scale),
        .TARGET_H_NUM(TARGET_H_NUM), .TARGET_V_NUM(TARGET_V_NUM),
        .pix_data(pix_data), .data_vaild(data_vaild),
        .wr_burst_req(wr_burst_req), .wr_burst_addr(wr_burst_addr), .wr_burst_len(wr_burst_len),
        .wr_burst_data_req(wr_burst_data_req), .wr_burst_data(wr_burst_data),
        .wr_burst_finish(wr_burst_finish),
        .frame_busy(frame_busy), .frame_done(frame_done), .ovf_err(ovf_err)
    );

    typedef struct {
        logic [27:0] addr;
        int          len;
    } burst_t;

    int total = 0;
    int bad   = 0;

    burst_t         exp_bursts[$];
    logic [15:0]    model_q[$];
    logic [27:0]    seen_addr[$];
    int             seen_len[$];

    int          m_h = 0, m_v = 0, m_col = 0, m_row = 0;
    logic [15:0] last_pix = '0;
    int          cur_len = 0, mon_pulls = 0;
    int          done_cnt = 0, done_base = 0;
    bit          stall = 0, abort_burst = 0, in_stall = 0;
    int          pull_first = -1, extra_pulls = 0;
    logic [FIX_LEN-1:0] sh_x, sh_y;
    logic [12:0]        sh_h, sh_v;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output-side scoreboard and input-side FIFO model, evaluated mid-cycle.
    initial begin : monitor
        logic [15:0] e;
        bit          popd;
        forever begin
            @(negedge clk);
            if (rstn) begin
                popd = 0;
                if (frame_done) done_cnt++;
                if (!wr_burst_req) mon_pulls = 0;
                else if (wr_burst_data_req) begin
                    if (mon_pulls < cur_len && model_q.size() > 0) begin
                        e = model_q.pop_front();
                        chk("pix", wr_burst_data, e);
                        last_pix = e;
                        mon_pulls++;
                        popd = 1;
                    end else begin
                        chk("pix_hold", wr_burst_data, last_pix);
                    end
                end
                if (data_vaild && m_row < m_v) begin
                    if (model_q.size() < FIFO_DEPTH || popd) model_q.push_back(pix_data);
                    if (m_col == m_h - 1) begin
                        m_col = 0;
                        m_row++;
                    end else begin
                        m_col++;
                    end
                end
            end
        end
    end

    initial begin : ddr_responder
        burst_t      b;
        int          n;
        logic [27:0] a0;
        wr_burst_data_req = 1'b0;
        wr_burst_finish   = 1'b0;
        forever begin
            @(negedge clk);
            if (wr_burst_req && rstn) begin
                a0 = wr_burst_addr;
                seen_addr.push_back(wr_burst_addr);
                seen_len.push_back(int'(wr_burst_len));
                chk("burst_expected", exp_bursts.size() != 0, 1);
                if (exp_bursts.size() != 0) begin
                    b = exp_bursts.pop_front();
                    chk("burst_addr", wr_burst_addr, b.addr);
                    chk("burst_len", wr_burst_len, b.len);
                end else begin
                    b.addr = wr_burst_addr;
                    b.len  = int'(wr_burst_len);
                end
                cur_len  = b.len;
                in_stall = 1;
                while (stall && !abort_burst) @(posedge clk);
                in_stall = 0;
                if (abort_burst) begin
                    abort_burst = 0;
                end else begin
                    n = (pull_first >= 0) ? pull_first : b.len + extra_pulls;
                    pull_first = -1;
                    repeat (n) begin
                        @(posedge clk); #1 wr_burst_data_req = 1'b1;
                    end
                    @(posedge clk); #1 wr_burst_data_req = 1'b0;
                    @(negedge clk);
                    chk("req_hold", {wr_burst_req, wr_burst_addr}, {1'b1, a0});
                    @(posedge clk); #1 wr_burst_finish = 1'b1;
                    @(posedge clk); #1 wr_burst_finish = 1'b0;
                    @(negedge clk);
                    chk("req_drop", wr_burst_req, 0);
                    chk("done_pulse", frame_done, exp_bursts.size() == 0);
                end
            end
        end
    end

    task automatic start_frame(input int h, input int v, input logic [27:0] base,
                               input logic [FIX_LEN-1:0] xs, input logic [FIX_LEN-1:0] ys);
        burst_t b;
        cfg_h_num     = 13'(h);
        cfg_v_num     = 13'(v);
        cfg_base_addr = base;
        cfg_x_scale   = xs;
        cfg_y_scale   = ys;
        seen_addr.delete();
        seen_len.delete();
        done_base = done_cnt;
        for (int r = 0; r < v; r++) begin
            for (int c = 0; c < h; c += BURST_LEN) begin
                b.addr = base + 28'(r * LINE_STRIDE) + 28'(c);
                b.len  = (h - c > BURST_LEN) ? BURST_LEN : h - c;
                exp_bursts.push_back(b);
            end
        end
        @(posedge clk); #1;
        frame_start = 1'b1;
        m_h = h; m_v = v; m_col = 0; m_row = 0;
        @(posedge clk); #1;
        frame_start = 1'b0;
        sh_x = xs; sh_y = ys; sh_h = 13'(h); sh_v = 13'(v);
        chk("shadow_x", x_scale, xs);
        chk("shadow_y", y_scale, ys);
        chk("shadow_h", TARGET_H_NUM, h);
        chk("shadow_v", TARGET_V_NUM, v);
        chk("busy_on", frame_busy, 1);
    endtask

    task automatic drive_pixels(input int n, input int pct);
        int sent = 0;
        while (sent < n) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 99) < pct) begin
                data_vaild = 1'b1;
                pix_data   = 16'($urandom);
                sent++;
            end else begin
                data_vaild = 1'b0;
            end
        end
        @(posedge clk); #1;
        data_vaild = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (done_cnt == done_base && k < 6000) begin
            @(posedge clk);
            k++;
        end
        chk({tag, "_done"}, done_cnt != done_base, 1);
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_done_once"}, done_cnt - done_base, 1);
        chk({tag, "_idle"}, frame_busy, 0);
        chk({tag, "_bursts_left"}, exp_bursts.size(), 0);
        chk({tag, "_pix_left"}, model_q.size(), 0);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin : main
        int k;
        rstn = 1'b0;
        cfg_x_scale = '0; cfg_y_scale = '0; cfg_h_num = '0; cfg_v_num = '0;
        cfg_base_addr = '0; frame_start = 1'b0; data_vaild = 1'b0; pix_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", wr_burst_req, 0);
        chk("rst_addr", wr_burst_addr, 0);
        chk("rst_len", wr_burst_len, 0);
        chk("rst_data", wr_burst_data, 0);
        chk("rst_scale", {x_scale, y_scale}, 0);
        chk("rst_hv", {TARGET_H_NUM, TARGET_V_NUM}, 0);
        chk("rst_flags", {frame_busy, frame_done, ovf_err}, 0);
        @(posedge clk); #1 rstn = 1'b1;
        repeat (2) @(posedge clk);

        // Two full rows at the default base.
        start_frame(640, 2, 28'h0003_8540, 15'h1234, 15'h0567);
        drive_pixels(1280, 80);
        wait_done("t1");
        chk("t1_bursts", seen_addr.size(), 40);
        if (seen_addr.size() > 20) chk("t1_row2_addr", seen_addr[20], 28'h0003_87C0);
        chk("t1_ovf", ovf_err, 0);

        // Short tail burst, over-long data requests, stray pixels after the frame.
        extra_pulls = 2;
        start_frame(100, 1, 28'h010_0000, 15'h0100, 15'h0200);
        drive_pixels(103, 80);
        wait_done("t2");
        extra_pulls = 0;
        chk("t2_bursts", seen_len.size(), 4);
        if (seen_len.size() == 4) begin
            chk("t2_len_last", seen_len[3], 4);
            chk("t2_addr_last", seen_addr[3], 28'h010_0060);
        end

        // Width changed mid-frame applies only to the next frame.
        start_frame(40, 2, 28'h020_0000, 15'h0011, 15'h0022);
        drive_pixels(30, 80);
        cfg_h_num = 13'd50;
        chk("t3_h_kept", TARGET_H_NUM, 40);
        drive_pixels(50, 80);
        wait_done("t3a");
        start_frame(50, 2, 28'hFFF_FFE0, 15'h0033, 15'h0044);
        drive_pixels(100, 80);
        wait_done("t3b");

        // frame_start while busy must not disturb the shadows.
        start_frame(64, 2, 28'h030_0000, 15'h0055, 15'h0066);
        drive_pixels(40, 80);
        cfg_h_num = 13'd10; cfg_v_num = 13'd3; cfg_x_scale = 15'h7FFF; cfg_y_scale = 15'h7FFF;
        @(posedge clk); #1 frame_start = 1'b1;
        @(posedge clk); #1 frame_start = 1'b0;
        chk("t4_shadow_x", x_scale, sh_x);
        chk("t4_shadow_hv", {TARGET_H_NUM, TARGET_V_NUM}, {sh_h, sh_v});
        drive_pixels(88, 80);
        wait_done("t4");
        chk("t4_ovf", ovf_err, 0);

        // DDR stalls while FIFO_DEPTH+5 pixels arrive.
        stall = 1;
        pull_first = 27;
        start_frame(69, 1, 28'h040_0000, 15'h0001, 15'h0002);
        drive_pixels(69, 80);
        chk("t5_ovf_set", ovf_err, 1);
        stall = 0;
        wait_done("t5");
        chk("t5_ovf_sticky", ovf_err, 1);

        // Reset while a burst is outstanding.
        stall = 1;
        start_frame(64, 1, 28'h050_0000, 15'h0003, 15'h0004);
        drive_pixels(40, 100);
        k = 0;
        while (!in_stall && k < 300) begin
            @(posedge clk);
            k++;
        end
        chk("t6_in_burst", in_stall, 1);
        @(posedge clk); #1 rstn = 1'b0;
        model_q.delete();
        exp_bursts.delete();
        m_v = 0; m_row = 0; m_col = 0; last_pix = '0;
        @(negedge clk);
        chk("t6_req", wr_burst_req, 0);
        chk("t6_shadow", {x_scale, y_scale, TARGET_H_NUM, TARGET_V_NUM}, 0);
        chk("t6_flags", {frame_busy, ovf_err}, 0);
        abort_burst = 1;
        stall = 0;
        @(posedge clk); #1 rstn = 1'b1;
        repeat (3) @(posedge clk);
        start_frame(64, 2, 28'h060_0000, 15'h0005, 15'h0006);
        drive_pixels(128, 80);
        wait_done("t6");
        chk("t6_ovf_clear", ovf_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
